song_reader: RTL and testbench

- Responder to the MCU's play/reset_player/song interface: fetches the selected song's notes from an external synchronous song ROM and hands them one at a time to the note player.
- Returns song_done to the MCU when the song ends.
- Sits between the MCU and the note player; the ROM is instantiated outside this block.

---
 rtl/song_reader_pkg.sv | 31 +++
 rtl/song_reader_if.sv | 39 +++
 rtl/song_reader_dffre.sv | 31 +++
 rtl/song_reader.sv | 179 +++++++++++++++++
 tb/tb_song_reader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/song_reader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | song_reader_pkg                                                  |
// | Shared types and default widths for the song reader block.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package song_reader_pkg;

  // Default field widths (16 songs x 32 notes, 6-bit note and duration)
  localparam int SONG_W_DEF  = 4;
  localparam int IDX_W_DEF   = 5;
  localparam int NOTE_W_DEF  = 6;
  localparam int DUR_W_DEF   = 6;
  localparam int ROM_LAT_DEF = 1;

  // A duration field of this value marks the end of a song
  localparam int END_MARKER = 0;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_ROM  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_END       = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/song_reader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | song_reader_if                                                   |
// | MCU control, song ROM port and note-player handshake bundle.     |
// | slave = song_reader side, master = surrounding system.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface song_reader_if
  import song_reader_pkg::*;
#(
  parameter int SONG_W = SONG_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
);

  logic                     play;
  logic                     reset_player;
  logic [SONG_W-1:0]        song;
  logic                     note_done;
  logic [SONG_W+IDX_W-1:0]  rom_addr;
  logic [NOTE_W+DUR_W-1:0]  rom_data;
  logic [NOTE_W-1:0]        note;
  logic [DUR_W-1:0]         duration;
  logic                     new_note;
  logic                     song_done;

  modport slave (
    input  play, reset_player, song, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );

  modport master (
    output play, reset_player, song, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );

endinterface
`default_nettype wire

// File: rtl/song_reader_dffre.sv
`default_nettype none
// +------------------------------------------------------------------+
// | song_reader_dffre                                                |
// | Flop with async reset, synchronous clear and load enable.        |
// | Both reset and clear return the flop to zero.                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module song_reader_dffre #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Async reset dominates, then sync clear, then enabled load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | song_reader                                                      |
// | Walks the selected song in an external synchronous ROM and hands |
// | each note to the note player, flagging song_done at the end.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module song_reader
  import song_reader_pkg::*;
#(
  parameter int SONG_W  = SONG_W_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int NOTE_W  = NOTE_W_DEF,
  parameter int DUR_W   = DUR_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  song_reader_if.slave bus
);

  localparam int LAT_W = $clog2(ROM_LAT + 1);

  state_t               state;
  state_t               state_nxt;
  logic [STATE_W-1:0]   state_bits;

  logic [IDX_W-1:0]     note_idx;
  logic [IDX_W-1:0]     note_idx_d;
  logic                 note_idx_en;

  logic [SONG_W-1:0]    song_q;
  logic                 song_en;

  logic [LAT_W-1:0]     lat_cnt;
  logic [LAT_W-1:0]     lat_cnt_d;
  logic                 lat_cnt_en;

  // Set when play dropped during a ROM read; the read is then re-issued
  logic                 refetch;
  logic                 refetch_d;
  logic                 refetch_en;

  logic [NOTE_W-1:0]    note_q;
  logic [DUR_W-1:0]     duration_q;
  logic                 capture;
  logic                 new_note_c;

  logic [NOTE_W-1:0]    rom_note;
  logic [DUR_W-1:0]     rom_dur;

  assign rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = bus.rom_data[DUR_W-1:0];

  // ---------------- state and datapath registers ----------------
  song_reader_dffre #(.WIDTH(STATE_W)) u_state (
    .clk(clk), .reset(reset), .clr(bus.reset_player), .en(1'b1),
    .d(state_nxt), .q(state_bits)
  );
  assign state = state_t'(state_bits);

  song_reader_dffre #(.WIDTH(IDX_W)) u_note_idx (
    .clk(clk), .reset(reset), .clr(bus.reset_player), .en(note_idx_en),
    .d(note_idx_d), .q(note_idx)
  );

  song_reader_dffre #(.WIDTH(SONG_W)) u_song_q (
    .clk(clk), .reset(reset), .clr(bus.reset_player), .en(song_en),
    .d(bus.song), .q(song_q)
  );

  song_reader_dffre #(.WIDTH(LAT_W)) u_lat_cnt (
    .clk(clk), .reset(reset), .clr(bus.reset_player), .en(lat_cnt_en),
    .d(lat_cnt_d), .q(lat_cnt)
  );

  song_reader_dffre #(.WIDTH(1)) u_refetch (
    .clk(clk), .reset(reset), .clr(bus.reset_player), .en(refetch_en),
    .d(refetch_d), .q(refetch)
  );

  song_reader_dffre #(.WIDTH(NOTE_W)) u_note (
    .clk(clk), .reset(reset), .clr(bus.reset_player), .en(capture),
    .d(rom_note), .q(note_q)
  );

  song_reader_dffre #(.WIDTH(DUR_W)) u_duration (
    .clk(clk), .reset(reset), .clr(bus.reset_player), .en(capture),
    .d(rom_dur), .q(duration_q)
  );

  // Next-state and register-load decode; play=0 freezes FETCH/WAIT_ROM/ISSUE
  always_comb begin
    state_nxt   = state;
    note_idx_en = 1'b0;
    note_idx_d  = note_idx + 1'b1;
    song_en     = 1'b0;
    lat_cnt_en  = 1'b0;
    lat_cnt_d   = lat_cnt - 1'b1;
    refetch_en  = 1'b0;
    refetch_d   = refetch;
    capture     = 1'b0;
    new_note_c  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.play) begin
          song_en     = 1'b1;
          note_idx_en = 1'b1;
          note_idx_d  = '0;
          state_nxt   = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (bus.play) begin
          lat_cnt_en = 1'b1;
          lat_cnt_d  = LAT_W'(ROM_LAT);
          refetch_en = 1'b1;
          refetch_d  = 1'b0;
          state_nxt  = ST_WAIT_ROM;
        end
      end

      ST_WAIT_ROM: begin
        if (!bus.play) begin
          refetch_en = 1'b1;
          refetch_d  = 1'b1;
        end else if (refetch) begin
          state_nxt = ST_FETCH;
        end else if (lat_cnt <= LAT_W'(1)) begin
          // Counter reaches zero on this edge: ROM word is valid now
          if (rom_dur == DUR_W'(END_MARKER)) begin
            state_nxt = ST_END;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end else begin
          lat_cnt_en = 1'b1;
        end
      end

      ST_ISSUE: begin
        if (bus.play) begin
          new_note_c = ~bus.reset_player;
          state_nxt  = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (bus.note_done) begin
          if (note_idx == {IDX_W{1'b1}}) begin
            state_nxt = ST_END;
          end else begin
            note_idx_en = 1'b1;
            state_nxt   = ST_FETCH;
          end
        end
      end

      ST_END: begin
        state_nxt = ST_END;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.rom_addr  = {song_q, note_idx};
  assign bus.note      = note_q;
  assign bus.duration  = duration_q;
  assign bus.new_note  = new_note_c;
  assign bus.song_done = (state == ST_END);

endmodule
`default_nettype wire

// File: tb/tb_song_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_song_reader                                                   |
// | Randomized self-checking bench: a ROM model plus a song-level    |
// | expectation (notes until end marker or 32 entries).              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_song_reader;

  localparam int SW = 4;
  localparam int IW = 5;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int AW = SW + IW;
  localparam int RW = NW + DW;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  song_reader_if #(.SONG_W(SW), .IDX_W(IW), .NOTE_W(NW), .DUR_W(DW)) bus ();
  song_reader_if #(.SONG_W(SW), .IDX_W(IW), .NOTE_W(NW), .DUR_W(DW)) bus3 ();

  song_reader #(.SONG_W(SW), .IDX_W(IW), .NOTE_W(NW), .DUR_W(DW), .ROM_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  song_reader #(.SONG_W(SW), .IDX_W(IW), .NOTE_W(NW), .DUR_W(DW), .ROM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  // Song ROM contents shared by both instances; each has its own read pipeline
  logic [RW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] a1;
  logic [AW-1:0] a3 [0:2];

  always @(posedge clk) begin
    a1    <= bus.rom_addr;
    a3[0] <= bus3.rom_addr;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end

  assign bus.rom_data  = mem[a1];
  assign bus3.rom_data = mem[a3[2]];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected number of notes a song yields: stop at first zero duration or 32
  function automatic int song_len(input int s);
    for (int k = 0; k < 32; k++) begin
      if (mem[s*32 + k][DW-1:0] == '0) return k;
    end
    return 32;
  endfunction

  function automatic logic [NW-1:0] exp_note(input int a);
    logic [RW-1:0] w;
    w = mem[a];
    return w[RW-1:DW];
  endfunction

  function automatic logic [DW-1:0] exp_dur(input int a);
    logic [RW-1:0] w;
    w = mem[a];
    return w[DW-1:0];
  endfunction

  // Wait (bounded) for a strobe and check latency and presented note
  task automatic wait_strobe(input int exp_lat, input int exp_addr, input string tag);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.note_done = 1'b0;
      if (bus.new_note) seen = 1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_addr"}, 32'(bus.rom_addr), exp_addr);
      chk({tag, "_note"}, 32'(bus.note), 32'(exp_note(exp_addr)));
      chk({tag, "_dur"}, 32'(bus.duration), 32'(exp_dur(exp_addr)));
      chk({tag, "_done_lo"}, 32'(bus.song_done), 32'd0);
    end
  endtask

  // Play one whole song; optional 10-cycle pause during the ROM read of note pause_at
  task automatic run_song(input int s, input int pause_at);
    int n;
    int addr;
    int dly;
    n = song_len(s);
    bus.song = SW'(s);
    bus.play = 1'b1;
    for (int k = 0; k < n; k++) begin
      addr = s*32 + k;
      if (k == pause_at) begin
        @(negedge clk);
        bus.note_done = 1'b0;
        @(negedge clk);
        bus.play = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("pause_quiet", 32'(bus.new_note), 32'd0);
          chk("pause_addr", 32'(bus.rom_addr), addr);
        end
        bus.play = 1'b1;
        wait_strobe(3, addr, "resume");
      end else begin
        wait_strobe(3, addr, "note");
      end
      dly = $urandom_range(1, 4);
      repeat (dly) begin
        @(negedge clk);
        bus.play = 1'($urandom_range(0, 1));
        chk("hold_quiet", 32'(bus.new_note), 32'd0);
        chk("hold_note", 32'(bus.note), 32'(exp_note(addr)));
      end
      bus.play      = 1'b1;
      bus.note_done = 1'b1;
    end
    repeat (8) begin
      @(negedge clk);
      bus.note_done = 1'b0;
      chk("no_extra", 32'(bus.new_note), 32'd0);
    end
    chk("song_done", 32'(bus.song_done), 32'd1);
    @(negedge clk);
    chk("done_held", 32'(bus.song_done), 32'd1);
    bus.reset_player = 1'b1;
    bus.play         = 1'b0;
    @(negedge clk);
    bus.reset_player = 1'b0;
    chk("rp_done_lo", 32'(bus.song_done), 32'd0);
    chk("rp_addr", 32'(bus.rom_addr), 32'd0);
    chk("rp_note", 32'(bus.note), 32'd0);
  endtask

  initial begin
    int s;
    int e;
    int lat;
    bit seen;

    reset = 1'b1;
    bus.play = 1'b0;  bus.reset_player = 1'b0;  bus.song = '0;  bus.note_done = 1'b0;
    bus3.play = 1'b0; bus3.reset_player = 1'b0; bus3.song = '0; bus3.note_done = 1'b0;

    // Random ROM with random end-marker positions (some songs have none)
    for (int a = 0; a < (1<<AW); a++) begin
      mem[a] = {NW'($urandom), DW'($urandom_range(1, 63))};
    end
    for (int t = 0; t < 16; t++) begin
      e = $urandom_range(0, 47);
      if (e < 32) mem[t*32 + e] = {exp_note(t*32 + e), DW'(0)};
    end
    // Directed contents
    for (int k = 0; k < 32; k++) mem[3*32 + k] = {NW'($urandom), DW'($urandom_range(1, 63))};
    mem[12'h060] = {6'h12, 6'h08};
    for (int k = 0; k < 3; k++) mem[5*32 + k] = {NW'(k + 1), DW'(k + 2)};
    mem[5*32 + 2] = {6'h3F, 6'h00};
    mem[2*32] = {6'h05, 6'h07};
    mem[7*32] = {6'h2A, 6'h11};
    mem[9*32] = {6'h33, 6'h21};

    repeat (3) @(negedge clk);
    chk("rst_note", 32'(bus.note), 32'd0);
    chk("rst_dur", 32'(bus.duration), 32'd0);
    chk("rst_new", 32'(bus.new_note), 32'd0);
    chk("rst_done", 32'(bus.song_done), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full 32-note song, end marker at word 2, pause in WAIT_ROM
    run_song(3, -1);
    run_song(5, -1);
    run_song(4, 1);

    // reset_player together with note_done and a song change
    bus.song = 4'd2;
    bus.play = 1'b1;
    wait_strobe(3, 2*32, "pre_rp");
    @(negedge clk);
    bus.note_done    = 1'b1;
    bus.reset_player = 1'b1;
    bus.song         = 4'd7;
    bus.play         = 1'b0;
    @(negedge clk);
    bus.note_done    = 1'b0;
    bus.reset_player = 1'b0;
    chk("rpnd_addr", 32'(bus.rom_addr), 32'd0);
    chk("rpnd_new", 32'(bus.new_note), 32'd0);
    bus.play = 1'b1;
    wait_strobe(3, 7*32, "post_rp");
    bus.reset_player = 1'b1;
    bus.play         = 1'b0;
    @(negedge clk);
    bus.reset_player = 1'b0;

    // Random songs with random pauses
    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, 15);
      run_song(s, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1);
    end

    // Async reset while a strobe is on the outputs
    bus.song = 4'd9;
    bus.play = 1'b1;
    wait_strobe(3, 9*32, "pre_arst");
    #2 reset = 1'b1;
    #1;
    chk("arst_new", 32'(bus.new_note), 32'd0);
    chk("arst_note", 32'(bus.note), 32'd0);
    chk("arst_dur", 32'(bus.duration), 32'd0);
    chk("arst_addr", 32'(bus.rom_addr), 32'd0);
    chk("arst_done", 32'(bus.song_done), 32'd0);
    bus.play = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Three-cycle ROM: strobe five cycles after play is first sampled
    bus3.song = 4'd9;
    bus3.play = 1'b1;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus3.new_note) seen = 1;
    end
    chk("lat3_seen", 32'(seen), 32'd1);
    chk("lat3_lat", lat, 32'd5);
    chk("lat3_note", 32'(bus3.note), 32'h33);
    chk("lat3_dur", 32'(bus3.duration), 32'h21);
    bus3.play = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
